// File: rtl/program_counter_reg.sv
// program_counter_reg: architectural PC register with PC+4, load counter
// and alignment flag. Optional macro: PC_ALIGN_CHECK_EN enables Misaligned.
module program_counter_reg #(
    parameter int unsigned WIDTH       = 64,
    parameter logic [63:0] RESET_VALUE = 64'h0,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     PC_In,
    output logic [WIDTH-1:0]     PC_Out,
    output logic [WIDTH-1:0]     PC_Plus4,
    output logic [CNT_WIDTH-1:0] Load_Count,
    output logic                 Misaligned
);

    // RESET_VALUE is truncated or zero-extended to the PC width.
    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0]     pc_d;
    logic [WIDTH-1:0]     pc_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_q;

    // Next state: reset wins, otherwise load PC_In verbatim and count.
    always_comb begin
        pc_d  = PC_In;
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (reset) begin
            pc_d  = RST_PC;
            cnt_d = '0;
        end
    end

    // State registers, synchronous reset folded into the next-state logic.
    always_ff @(posedge clock) begin
        pc_q  <= pc_d;
        cnt_q <= cnt_d;
    end

    assign PC_Out     = pc_q;
    assign PC_Plus4   = pc_q + WIDTH'(4);
    assign Load_Count = cnt_q;

`ifdef PC_ALIGN_CHECK_EN
    assign Misaligned = (pc_q[1:0] != 2'b00);
`else
    assign Misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_reg.sv
// tb_program_counter_reg: directed and randomized checks of the PC register
// against a reference model; second instance covers narrow width and wrap.
module tb_program_counter_reg;

    logic        clock;
    logic        reset;
    logic [63:0] PC_In;
    logic [63:0] PC_Out;
    logic [63:0] PC_Plus4;
    logic [31:0] Load_Count;
    logic        Misaligned;

    logic [15:0] n_out;
    logic [15:0] n_plus4;
    logic [2:0]  n_cnt;
    logic        n_mis;

    int total;
    int bad;

    // reference model
    logic [63:0] pc_m;
    logic [15:0] pcn_m;
    longint unsigned loads;

    program_counter_reg dut (
        .clock(clock), .reset(reset), .PC_In(PC_In),
        .PC_Out(PC_Out), .PC_Plus4(PC_Plus4),
        .Load_Count(Load_Count), .Misaligned(Misaligned)
    );

    program_counter_reg #(
        .WIDTH(16), .RESET_VALUE(64'h1234_0008), .CNT_WIDTH(3)
    ) dut_n (
        .clock(clock), .reset(reset), .PC_In(PC_In[15:0]),
        .PC_Out(n_out), .PC_Plus4(n_plus4),
        .Load_Count(n_cnt), .Misaligned(n_mis)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic exp_mis(input logic [63:0] v);
`ifdef PC_ALIGN_CHECK_EN
        return (v % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // drive on falling edge, update model at rising edge, settle 1 unit
    task automatic tick(input logic r, input logic [63:0] v);
        @(negedge clock);
        reset = r;
        PC_In = v;
        @(posedge clock);
        if (r) begin
            pc_m  = 64'h0;
            pcn_m = 16'h0008;
            loads = 0;
        end else begin
            pc_m  = v;
            pcn_m = v[15:0];
            loads = loads + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 64'h1234);
        total++;
        if (PC_Out !== 64'h0) begin
            bad++; $display("FAIL reset_pc got=%h exp=0", PC_Out);
        end
        total++;
        if (Load_Count !== 32'd0) begin
            bad++; $display("FAIL reset_cnt got=%0d exp=0", Load_Count);
        end
        total++;
        if (PC_Plus4 !== 64'd4) begin
            bad++; $display("FAIL reset_plus4 got=%h exp=4", PC_Plus4);
        end
        total++;
        if (Misaligned !== 1'b0) begin
            bad++; $display("FAIL reset_mis got=%b exp=0", Misaligned);
        end
        total++;
        if (n_out !== 16'h0008 || n_cnt !== 3'd0) begin
            bad++;
            $display("FAIL reset_narrow got=%h/%0d exp=0008/0", n_out, n_cnt);
        end
    endtask

    task automatic test_load();
        tick(1'b0, 64'd10);
        total++;
        if (PC_Out !== 64'd10 || PC_Plus4 !== 64'd14) begin
            bad++;
            $display("FAIL load10 got=%0d/%0d exp=10/14", PC_Out, PC_Plus4);
        end
        begin
            logic [31:0] c0;
            c0 = Load_Count;
            tick(1'b0, 64'd20);
            tick(1'b0, 64'd20);
            total++;
            if (PC_Out !== 64'd20 || Load_Count !== c0 + 32'd2) begin
                bad++;
                $display("FAIL hold20 got=%0d/%0d exp=20/%0d",
                         PC_Out, Load_Count, c0 + 32'd2);
            end
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b0, 64'd6);
        total++;
        if (PC_Out !== 64'd6 || Misaligned !== exp_mis(64'd6)) begin
            bad++;
            $display("FAIL b2b6 got=%0d/%b exp=6/%b",
                     PC_Out, Misaligned, exp_mis(64'd6));
        end
        tick(1'b0, 64'd12);
        total++;
        if (PC_Out !== 64'd12 || Misaligned !== 1'b0) begin
            bad++;
            $display("FAIL b2b12 got=%0d/%b exp=12/0", PC_Out, Misaligned);
        end
        tick(1'b1, 64'd12);
        total++;
        if (PC_Out !== 64'd0 || Load_Count !== 32'd0) begin
            bad++;
            $display("FAIL midreset got=%0d/%0d exp=0/0", PC_Out, Load_Count);
        end
        tick(1'b0, 64'd12);
        total++;
        if (PC_Out !== 64'd12 || Load_Count !== 32'd1) begin
            bad++;
            $display("FAIL release got=%0d/%0d exp=12/1", PC_Out, Load_Count);
        end
    endtask

    task automatic test_toggle();
        @(negedge clock);
        PC_In = 64'd5;
        #3 PC_In = 64'd9;
        #3 PC_In = 64'd5;
        total++;
        if (PC_Out !== 64'd12) begin
            bad++; $display("FAIL between_edges got=%0d exp=12", PC_Out);
        end
        @(posedge clock);
        pc_m  = 64'd5;
        pcn_m = 16'd5;
        loads = loads + 1;
        #1;
        total++;
        if (PC_Out !== 64'd5) begin
            bad++; $display("FAIL toggle_edge got=%0d exp=5", PC_Out);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 64'hFFFF_FFFF_FFFF_FFFC);
        total++;
        if (PC_Out !== 64'hFFFF_FFFF_FFFF_FFFC || PC_Plus4 !== 64'h0) begin
            bad++;
            $display("FAIL plus4_wrap got=%h/%h exp=fffffffffffffffc/0",
                     PC_Out, PC_Plus4);
        end
        tick(1'b1, 64'h0);
        for (int i = 1; i <= 9; i++) begin
            tick(1'b0, 64'(i * 3));
            total++;
            if (n_cnt !== 3'(i % 8) || Load_Count !== 32'(i)) begin
                bad++;
                $display("FAIL cnt_wrap i=%0d got=%0d/%0d exp=%0d/%0d",
                         i, n_cnt, Load_Count, i % 8, i);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic r;
            logic [63:0] v;
            r = ($urandom_range(0, 15) == 0);
            v = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0)
                v = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
            tick(r, v);
            total++;
            if (PC_Out !== pc_m || PC_Plus4 !== pc_m + 64'd4) begin
                bad++;
                $display("FAIL rnd_pc i=%0d got=%h/%h exp=%h/%h",
                         i, PC_Out, PC_Plus4, pc_m, pc_m + 64'd4);
            end
            total++;
            if (Load_Count !== 32'(loads) || Misaligned !== exp_mis(pc_m)) begin
                bad++;
                $display("FAIL rnd_cnt i=%0d got=%0d/%b exp=%0d/%b",
                         i, Load_Count, Misaligned, loads, exp_mis(pc_m));
            end
            total++;
            if (n_out !== pcn_m || n_plus4 !== pcn_m + 16'd4 ||
                n_cnt !== 3'(loads % 8) || n_mis !== exp_mis(64'(pcn_m))) begin
                bad++;
                $display("FAIL rnd_narrow i=%0d got=%h/%h/%0d/%b exp=%h/%h/%0d/%b",
                         i, n_out, n_plus4, n_cnt, n_mis, pcn_m,
                         pcn_m + 16'd4, loads % 8, exp_mis(64'(pcn_m)));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        PC_In = '0;
        pc_m  = '0;
        pcn_m = '0;
        loads = 0;
        test_reset();
        test_load();
        test_back_to_back();
        test_toggle();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
